// File: rtl/frame_sync_if.sv
// Serial receive front-end bundle: line bit in, forwarded bit plus payload
// window and frame status out.
interface frame_sync_if;
  logic       din;
  logic       dout;
  logic       buff_ena;
  logic       done;
  logic       busy;
  logic [7:0] frm_cnt;

  modport master (output din, input dout, buff_ena, done, busy, frm_cnt);
  modport slave  (input din, output dout, buff_ena, done, busy, frm_cnt);
endinterface

// File: rtl/frame_sync.sv
// SFD hunter with bit-error tolerance; forwards NDATA payload bits under an
// enable window and pulses done when the downstream word is complete.
module frame_sync #(
  parameter int              NDATA  = 128,
  parameter int              NSFD   = 16,
  parameter logic [NSFD-1:0] SFD    = 16'hA5C3,
  parameter int              ERRTOL = 1
) (
  input  logic         clk,
  input  logic         rst,
  frame_sync_if.slave  bus
);

  localparam int CW = $clog2(NDATA);
  localparam int FW = $clog2(NSFD + 1);

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [NSFD-1:0] SFD_INV = ~SFD;

  logic [1:0]      state_q, state_d;
  logic [NSFD-1:0] sreg_q, sreg_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      frm_q, frm_d;
  logic            dout_q;
  logic            ena_q, ena_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            match_s;

  function automatic logic [FW-1:0] popcount(input logic [NSFD-1:0] v);
    logic [FW-1:0] n;
    n = {FW{1'b0}};
    for (int i = 0; i < NSFD; i++) begin
      n = n + {{(FW-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  // With ERRTOL > 0 the ~SFD reload alone would let a pattern match after
  // only NSFD-ERRTOL fresh bits, so a fresh-bit count gates the match too.
  assign match_s = (popcount(sreg_q ^ SFD) <= FW'(ERRTOL)) && (fill_q == FW'(NSFD));

  // Next-state logic for the hunt/load/done sequence and its registered outputs.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    frm_d   = frm_q;
    ena_d   = 1'b0;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      ST_HUNT: begin
        sreg_d = {sreg_q[NSFD-2:0], bus.din};
        if (fill_q != FW'(NSFD)) begin
          fill_d = fill_q + FW'(1);
        end else begin
          fill_d = fill_q;
        end
        if (match_s) begin
          state_d = ST_LOAD;
          cnt_d   = {CW{1'b0}};
          ena_d   = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_LOAD: begin
        cnt_d  = cnt_q + CW'(1);
        busy_d = 1'b1;
        if (cnt_q == CW'(NDATA - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          ena_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_HUNT;
        frm_d   = frm_q + 8'd1;
        sreg_d  = SFD_INV;
        fill_d  = {FW{1'b0}};
      end
      default: begin
        state_d = ST_HUNT;
        sreg_d  = SFD_INV;
        fill_d  = {FW{1'b0}};
      end
    endcase
  end

  // State and output registers; reset clears the window without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_HUNT;
      sreg_q  <= SFD_INV;
      fill_q  <= FW'(NSFD);
      cnt_q   <= {CW{1'b0}};
      frm_q   <= 8'd0;
      dout_q  <= 1'b0;
      ena_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      frm_q   <= frm_d;
      dout_q  <= bus.din;
      ena_q   <= ena_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.buff_ena = ena_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.frm_cnt  = frm_q;

endmodule

// File: tb/tb_frame_sync.sv
// Directed plus randomized bench for frame_sync, checked cycle by cycle
// against a line-history reference model.
module tb_frame_sync;

  localparam int          NDATA  = 128;
  localparam int          NSFD   = 16;
  localparam int          ERRTOL = 1;
  localparam logic [15:0] SFD    = 16'hA5C3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  frame_sync_if ifc ();

  frame_sync #(.NDATA(NDATA), .NSFD(NSFD), .SFD(SFD), .ERRTOL(ERRTOL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference model: fresh line bits since reset or since the last frame end
  bit   fresh[$];
  bit   from_reset;
  bit   in_frame;
  int   t, k, frames;
  logic [15:0] line_w;

  int   ena_cycles, done_pulses, rise_t, sfd_t;
  logic prev_ena;
  logic [NDATA-1:0] capture;

  task automatic check(input string tag, input logic [NDATA-1:0] obs, input logic [NDATA-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int hd16(input logic [15:0] a, input logic [15:0] b);
    int d = 0;
    for (int i = 0; i < 16; i++) if (a[i] != b[i]) d++;
    return d;
  endfunction

  // Hamming distance of the current hunt window; windows not yet filled with
  // fresh bits after a frame can never match.
  function automatic int window_dist();
    logic [15:0] w;
    logic [15:0] inv;
    int n;
    inv = ~SFD;
    n = fresh.size();
    for (int i = 0; i < NSFD; i++) begin
      if (i < n) w[i] = fresh[n-1-i];
      else if (from_reset) w[i] = inv[i-n];
      else return NSFD + 1;
    end
    return hd16(w, SFD);
  endfunction

  task automatic model_reset();
    in_frame   = 1'b0;
    frames     = 0;
    from_reset = 1'b1;
    fresh.delete();
    line_w     = ~SFD;
  endtask

  task automatic clr();
    ena_cycles  = 0;
    done_pulses = 0;
    rise_t      = -1;
    capture     = '0;
  endtask

  task automatic cyc(input logic b);
    logic e_ena, e_done, e_busy;
    int age;
    ifc.din = b;
    @(posedge clk);
    #1;
    t++;
    line_w = {line_w[14:0], b};
    e_ena = 1'b0; e_done = 1'b0; e_busy = 1'b0;
    if (in_frame) begin
      age    = t - k;
      e_ena  = (age >= 1) && (age <= NDATA);
      e_done = (age == NDATA + 1);
      e_busy = (age <= NDATA + 1);
      if (age == NDATA + 2) begin
        frames++;
        in_frame   = 1'b0;
        from_reset = 1'b0;
        fresh.delete();
      end
    end else begin
      fresh.push_back(b);
      if (fresh.size() > NSFD) void'(fresh.pop_front());
      if (window_dist() <= ERRTOL) begin
        in_frame = 1'b1;
        k        = t;
      end
    end
    check("dout", ifc.dout, b);
    check("buff_ena", ifc.buff_ena, e_ena);
    check("done", ifc.done, e_done);
    check("busy", ifc.busy, e_busy);
    check("frm_cnt", ifc.frm_cnt, frames % 256);
    if (ifc.buff_ena) begin
      ena_cycles++;
      capture = {capture[NDATA-2:0], ifc.dout};
    end
    if (ifc.done) done_pulses++;
    if (ifc.buff_ena && !prev_ena) rise_t = t;
    prev_ena = ifc.buff_ena;
  endtask

  task automatic send16(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) cyc(w[i]);
  endtask

  task automatic send_payload(input logic [NDATA-1:0] p);
    for (int i = NDATA - 1; i >= 0; i--) cyc(p[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  // random bits, steered away from anything close to the SFD
  task automatic send_preamble(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      if (hd16({line_w[14:0], b}, SFD) <= ERRTOL + 1) b = ~b;
      cyc(b);
    end
  endtask

  function automatic logic [NDATA-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [NDATA-1:0] p;

  initial begin
    ifc.din  = 1'b0;
    t        = 0;
    k        = 0;
    prev_ena = 1'b0;
    model_reset();
    clr();
    #12;
    check("rst_dout", ifc.dout, 0);
    check("rst_buff_ena", ifc.buff_ena, 0);
    check("rst_done", ifc.done, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_frm_cnt", ifc.frm_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // exact SFD after random preamble
    clr();
    send_preamble(40);
    send16(SFD);
    sfd_t = t;
    p = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    send_payload(p);
    send_zeros(6);
    check("t1_ena_cycles", ena_cycles, 128);
    check("t1_ena_start", rise_t - sfd_t, 1);
    check("t1_payload", capture, p);
    check("t1_done_pulses", done_pulses, 1);
    check("t1_frm_cnt", ifc.frm_cnt, 1);

    // one flipped SFD bit accepted, two rejected
    clr();
    send_zeros(4);
    send16(16'hA5C2);
    p = rnd128();
    send_payload(p);
    send_zeros(6);
    check("t2_one_err_ena", ena_cycles, 128);
    check("t2_one_err_payload", capture, p);
    check("t2_one_err_frm", ifc.frm_cnt, 2);
    clr();
    send16(16'hA5C0);
    send_payload('0);
    send_zeros(4);
    check("t2_two_err_ena", ena_cycles, 0);
    check("t2_two_err_frm", ifc.frm_cnt, 2);

    // SFD embedded at payload bits 40..55
    clr();
    send_zeros(2);
    send16(SFD);
    p = rnd128();
    p[87:72] = SFD;
    send_payload(p);
    send_zeros(6);
    check("t3_ena_cycles", ena_cycles, 128);
    check("t3_done_pulses", done_pulses, 1);
    check("t3_payload", capture, p);
    check("t3_frm_cnt", ifc.frm_cnt, 3);

    // minimum gap accepted, one cycle shorter misses the second frame
    clr();
    send16(SFD);
    send_payload(rnd128());
    send_zeros(2);
    send16(SFD);
    p = rnd128();
    send_payload(p);
    send_zeros(6);
    check("t4_gap18_done", done_pulses, 2);
    check("t4_gap18_payload", capture, p);
    check("t4_gap18_frm", ifc.frm_cnt, 5);
    clr();
    send16(SFD);
    send_payload(rnd128());
    send_zeros(1);
    send16(SFD);
    send_payload('0);
    send_zeros(6);
    check("t4_gap17_done", done_pulses, 1);
    check("t4_gap17_frm", ifc.frm_cnt, 6);

    // asynchronous reset in the middle of a payload
    send_zeros(2);
    send16(SFD);
    p = rnd128();
    p[127-59] = 1'b1;
    for (int i = 0; i < 60; i++) cyc(p[127-i]);
    check("t5_pre_ena", ifc.buff_ena, 1);
    #3;
    rst = 1'b0;
    #1;
    check("t5_rst_ena", ifc.buff_ena, 0);
    check("t5_rst_busy", ifc.busy, 0);
    check("t5_rst_dout", ifc.dout, 0);
    check("t5_rst_frm", ifc.frm_cnt, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    prev_ena = 1'b0;
    clr();
    send_preamble(20);
    send16(SFD);
    p = rnd128();
    send_payload(p);
    send_zeros(6);
    check("t5_after_ena", ena_cycles, 128);
    check("t5_after_payload", capture, p);
    check("t5_after_frm", ifc.frm_cnt, 1);

    // 256 frames from reset: counter wraps
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    prev_ena = 1'b0;
    clr();
    send_zeros(2);
    for (int f = 1; f <= 256; f++) begin
      send16(SFD);
      send_payload(rnd128());
      send_zeros(2);
      if (f == 255) check("t6_frm_255", ifc.frm_cnt, 255);
      if (f == 256) check("t6_frm_wrap", ifc.frm_cnt, 0);
    end
    check("t6_done_pulses", done_pulses, 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
